// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage add/sub datapath.
//   DATA_W          default operand/result width
//   FLAG_N..FLAG_V  bit positions of the NZCV nibble
//   flags_t         packed {n, z, c, v}; layout matches the FLAG_* positions
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W = 64;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Valid/ready bundle between the operand producer and the pipelined adder.
//   request  : in_valid, in_ready, a, b, cin, sub, tag_in
//   response : out_valid, out_ready, sum, tag_out, flags ({N,Z,C,V})
// Modports: master = producer/consumer side, slave = adder side.
// -----------------------------------------------------------------------------
interface pipelined_adder_if
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int TAG_W = 5
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic [TAG_W-1:0] tag_in;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic [TAG_W-1:0] tag_out;
   logic [3:0]       flags;

   modport master (
      output in_valid, a, b, cin, sub, tag_in, out_ready,
      input  in_ready, out_valid, sum, tag_out, flags
   );

   modport slave (
      input  in_valid, a, b, cin, sub, tag_in, out_ready,
      output in_ready, out_valid, sum, tag_out, flags
   );

endinterface

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CW-bit ripple-carry adder, one instance per pipeline stage.
//   a, b  : CW-bit addends
//   cin   : carry in
//   s     : CW-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_chunk #(
   parameter int CW = 16
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] s,
   output logic          cout
);

   // Bit-serial ripple: each bit's carry feeds the next bit.
   always_comb begin : ripple
      logic carry;
      carry = cin;
      s     = {CW{1'b0}};
      for (int i = 0; i < CW; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit add/subtract split into STAGES equal chunks; stage k ripples chunk k
// with the carry registered by stage k-1 (stage 0 takes cin). Result =
// a + (sub ? ~b : b) + cin. Latency STAGES, one operation per cycle, global
// stall: advance = !out_valid || out_ready, in_ready = advance.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/a/b/cin/sub/tag_in request side,
//                  out_valid/out_ready/sum/tag_out/flags response side
// Build option: PIPELINED_ADDER_FLAGS_EN enables the registered NZCV flags;
// without it flags reads 4'b0000 and no flag logic is generated.
// -----------------------------------------------------------------------------
module pipelined_adder
   import alu_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int STAGES = 4,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   pipelined_adder_if.slave bus
);

   localparam int CW = WIDTH / STAGES;

   logic             advance_s;
   logic [WIDTH-1:0] b_eff_s;

   // Per-stage combinational inputs and results.
   logic             vld_in_s  [STAGES];
   logic [WIDTH-1:0] word_in_s [STAGES];
   logic [WIDTH-1:0] bp_in_s   [STAGES];
   logic             c_in_s    [STAGES];
   logic [TAG_W-1:0] tag_in_s  [STAGES];
   logic [WIDTH-1:0] word_nx_s [STAGES];
   logic             co_s      [STAGES];

   // Per-stage registers. word_r holds finished sum chunks in its low part and
   // the not-yet-consumed chunks of a in its high part; bp_r skews b_eff.
   logic             vld_r  [STAGES];
   logic [WIDTH-1:0] word_r [STAGES];
   logic [WIDTH-1:0] bp_r   [STAGES];
   logic             c_r    [STAGES];
   logic [TAG_W-1:0] tag_r  [STAGES];

   assign advance_s = !vld_r[STAGES-1] || bus.out_ready;
   assign b_eff_s   = bus.sub ? ~bus.b : bus.b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CW-1:0]    sum_chunk_s;
      logic [WIDTH-1:0] merged_s;

      if (k == 0) begin : g_first
         assign vld_in_s[k]  = bus.in_valid;
         assign word_in_s[k] = bus.a;
         assign bp_in_s[k]   = b_eff_s;
         assign c_in_s[k]    = bus.cin;
         assign tag_in_s[k]  = bus.tag_in;
      end else begin : g_rest
         assign vld_in_s[k]  = vld_r[k-1];
         assign word_in_s[k] = word_r[k-1];
         assign bp_in_s[k]   = bp_r[k-1];
         assign c_in_s[k]    = c_r[k-1];
         assign tag_in_s[k]  = tag_r[k-1];
      end

      adder_chunk #(.CW(CW)) u_chunk (
         .a    (word_in_s[k][k*CW +: CW]),
         .b    (bp_in_s[k][k*CW +: CW]),
         .cin  (c_in_s[k]),
         .s    (sum_chunk_s),
         .cout (co_s[k])
      );

      // Overwrite chunk k of the travelling word with its finished sum.
      always_comb begin
         merged_s              = word_in_s[k];
         merged_s[k*CW +: CW]  = sum_chunk_s;
      end

      assign word_nx_s[k] = merged_s;
   end

   // Stage registers: cleared on reset, all advance together or all hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_r[k]  <= 1'b0;
            word_r[k] <= {WIDTH{1'b0}};
            bp_r[k]   <= {WIDTH{1'b0}};
            c_r[k]    <= 1'b0;
            tag_r[k]  <= {TAG_W{1'b0}};
         end
      end else if (advance_s) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_r[k]  <= vld_in_s[k];
            word_r[k] <= word_nx_s[k];
            bp_r[k]   <= bp_in_s[k];
            c_r[k]    <= co_s[k];
            tag_r[k]  <= tag_in_s[k];
         end
      end
   end

`ifdef PIPELINED_ADDER_FLAGS_EN
   flags_t flags_nx_s;
   flags_t flags_r;

   // At the last stage the top chunk of word_in still holds a, and bp_in
   // still holds b_eff, so their MSBs are the operand signs needed for V.
   always_comb begin
      flags_nx_s.n = word_nx_s[STAGES-1][WIDTH-1];
      flags_nx_s.z = (word_nx_s[STAGES-1] == {WIDTH{1'b0}});
      flags_nx_s.c = co_s[STAGES-1];
      flags_nx_s.v = (word_in_s[STAGES-1][WIDTH-1] == bp_in_s[STAGES-1][WIDTH-1]) &&
                     (word_nx_s[STAGES-1][WIDTH-1] != word_in_s[STAGES-1][WIDTH-1]);
   end

   // Flags register, loaded alongside the final sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_r <= 4'b0000;
      end else if (advance_s) begin
         flags_r <= flags_nx_s;
      end
   end

   assign bus.flags = flags_r;
`else
   assign bus.flags = 4'b0000;
`endif

   assign bus.in_ready  = advance_s;
   assign bus.out_valid = vld_r[STAGES-1];
   assign bus.sum       = word_r[STAGES-1];
   assign bus.tag_out   = tag_r[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Scoreboard bench: every accepted operation pushes its expected result (from a
// plain-arithmetic model) into a queue; a monitor pops and compares on every
// output transfer.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int W  = 64;
   localparam int S  = 4;
   localparam int TW = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W), .TAG_W(TW)) bif ();

   pipelined_adder #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   typedef struct {
      logic [W-1:0]  sum;
      logic [TW-1:0] tag;
      logic [3:0]    flags;
   } exp_t;

   exp_t sb[$];
   int   pop_cyc[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   rand_done;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference: full-width arithmetic, flags from the NZCV definitions.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic [TW-1:0] tag);
      exp_t         e;
      logic [W:0]   full;
      logic [W-1:0] be;
      be    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin};
      e.sum = full[W-1:0];
      e.tag = tag;
`ifdef PIPELINED_ADDER_FLAGS_EN
      e.flags = {full[W-1], (full[W-1:0] == {W{1'b0}}), full[W],
                 (a[W-1] == be[W-1]) && (full[W-1] != a[W-1])};
`else
      e.flags = 4'b0000;
`endif
      return e;
   endfunction

   // Monitor: compare on every output transfer.
   always @(negedge clk) begin
      if (reset_n && bif.out_valid && bif.out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got sum %h tag %0d, expected no output", bif.sum, bif.tag_out);
         end else begin
            mon_e = sb.pop_front();
            chk("sum",   bif.sum,            mon_e.sum);
            chk("tag",   W'(bif.tag_out),    W'(mon_e.tag));
            chk("flags", W'(bif.flags),      W'(mon_e.flags));
            pop_cyc.push_back(cyc);
         end
      end
   end

   // Present one op (caller at posedge+1); returns at posedge+1 after accept.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [TW-1:0] tag);
      bit done = 1'b0;
      bif.a = a; bif.b = b; bif.cin = cin; bif.sub = sub; bif.tag_in = tag;
      bif.in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bif.in_ready) begin
            sb.push_back(model(a, b, cin, sub, tag));
            done = 1'b1;
         end
         @(posedge clk);
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready 0 for 200 cycles, expected 1");
      end
      #1 bif.in_valid = 1'b0;
   endtask

   // Single op on an empty, unstalled pipe; checks exact latency S.
   task automatic lat_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [TW-1:0] tag);
      bif.a = a; bif.b = b; bif.cin = cin; bif.sub = sub; bif.tag_in = tag;
      bif.in_valid = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", W'(bif.in_ready), W'(1'b1));
      sb.push_back(model(a, b, cin, sub, tag));
      @(posedge clk);
      #1 bif.in_valid = 1'b0;
      for (int i = 1; i < S; i++) begin
         @(negedge clk);
         chk("lat_early_valid", W'(bif.out_valid), W'(1'b0));
         @(posedge clk);
      end
      @(negedge clk);
      chk("lat_valid", W'(bif.out_valid), W'(1'b1));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int i = 0;
      while (sb.size() != 0 && i < 200) begin
         @(posedge clk);
         i++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ones = {W{1'b1}};
      bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.cin = 1'b0; bif.sub = 1'b0;
      bif.tag_in = '0; bif.out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", W'(bif.out_valid), W'(1'b0));
      chk("rst_sum",       bif.sum,           {W{1'b0}});
      chk("rst_tag",       W'(bif.tag_out),   W'(5'd0));
      chk("rst_flags",     W'(bif.flags),     W'(4'd0));
      chk("rst_in_ready",  W'(bif.in_ready),  W'(1'b1));
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Wrap with exact latency, then directed carry/sub/overflow cases
      lat_op(ones, 64'd1, 1'b0, 1'b0, 5'd3);
      send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 5'd4);
      send(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 5'd5);
      send(64'd5, 64'd7, 1'b1, 1'b1, 5'd6);
      send(64'd7, 64'd5, 1'b1, 1'b1, 5'd7);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 5'd8);
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 5'd9);
      drain();

      // Streaming: 8 back-to-back ops must emerge on consecutive cycles
      pop_cyc.delete();
      for (int t = 0; t < 8; t++) begin
         send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(1)),
              1'($urandom_range(1)), TW'(t));
      end
      drain();
      chk("stream_count", W'(pop_cyc.size()), W'(8));
      for (int i = 1; i < pop_cyc.size(); i++) begin
         chk("stream_consecutive", W'(pop_cyc[i]), W'(pop_cyc[0] + i));
      end

      // Stall: out_ready low for 3 cycles while the pipe is full
      fork
         begin
            for (int t = 0; t < 12; t++) begin
               send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0, TW'(t + 10));
            end
         end
         begin
            @(negedge clk);
            for (int k = 0; k < 50 && !bif.out_valid; k++) @(negedge clk);
            @(posedge clk);
            #2 bif.out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall_out_valid", W'(bif.out_valid), W'(1'b1));
               chk("stall_in_ready",  W'(bif.in_ready),  W'(1'b0));
               if (sb.size() != 0) begin
                  chk("stall_sum", bif.sum,          sb[0].sum);
                  chk("stall_tag", W'(bif.tag_out),  W'(sb[0].tag));
               end else begin
                  chk("stall_sb_nonempty", W'(sb.size()), W'(1));
               end
               @(posedge clk);
            end
            #2 bif.out_ready = 1'b1;
         end
      join
      drain();

      // Randomised traffic with bubbles and random back-pressure
      rand_done = 1'b0;
      fork
         begin
            for (int t = 0; t < 150; t++) begin
               if ($urandom_range(3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               ra = {$urandom(), $urandom()};
               rb = {$urandom(), $urandom()};
               if ($urandom_range(7) == 0) ra = ones;
               if ($urandom_range(7) == 0) rb = {W{1'b0}};
               send(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), TW'(t));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #2 bif.out_ready = ($urandom_range(3) != 0);
            end
            bif.out_ready = 1'b1;
         end
      join
      bif.out_ready = 1'b1;
      drain();

      // Reset mid-flight: two ops held in the pipe, reset between edges
      bif.out_ready = 1'b0;
      send(64'd100, 64'd200, 1'b0, 1'b0, 5'd21);
      send(64'd300, 64'd400, 1'b0, 1'b0, 5'd22);
      for (int k = 0; k < 20 && !bif.out_valid; k++) @(negedge clk);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", W'(bif.out_valid), W'(1'b0));
      chk("midrst_sum",       bif.sum,           {W{1'b0}});
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      lat_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 5'd30);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor; successor to the single-bit gate-level full adder.
- Splits the operand into STAGES equal chunks; each pipeline stage ripples one chunk and registers its carry.
- Long adds close timing at CPU clock rates.
- Sits in the execute stage as the ALU add/sub datapath; produces LEGv8 NZCV flags.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 64, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and chunk count; 1..WIDTH; chunk width CW = WIDTH/STAGES.
- TAG_W, 5, width of sideband tag carried alongside each operation (e.g. destination register).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operation presented this cycle.
- in_ready, output, 1, block accepts the operation this cycle.
- a, input, WIDTH, first operand.
- b, input, WIDTH, second operand.
- cin, input, 1, carry in (1 for SUB/SUBS, C flag for ADC/SBC).
- sub, input, 1, 1 = b is bitwise inverted before the add.
- tag_in, input, TAG_W, sideband passed through unchanged.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, result.
- tag_out, output, TAG_W, tag matching sum.
- flags, output, 4, {N,Z,C,V} of sum.

Behaviour:
- Reset: asynchronous on reset_n low, released synchronously to clk. Clears every stage valid bit, so out_valid=0. sum, tag_out and flags go to 0. Data registers are also cleared to 0.
- Reset mid-operation: all in-flight operations are discarded. No result is emitted for them.
- Operand conditioning: b_eff = sub ? ~b : b. Result = a + b_eff + cin, mod 2^WIDTH. cin is not forced by sub; the caller sets it.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff using the carry registered by stage k-1 (stage 0 uses cin).
  - Upper chunks not yet consumed are carried forward in skew registers.
  - Completed lower chunks are carried forward alongside them.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, when unstalled.
- Throughput: one operation per cycle.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Stall is global: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every stage register holds its value and sum/tag/flags stay stable.
  - Bubbles: an un-accepted cycle inserts valid=0 into stage 0. Bubbles are not compacted.
- in_ready does not depend on in_valid (no combinational loop). It depends combinationally on out_ready.
- Flags are computed from final-stage values and registered with sum:
  - N = sum[WIDTH-1].
  - Z = (sum == 0).
  - C = carry out of bit WIDTH-1.
  - V = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - The a and b_eff MSBs are carried down the pipe for V.
- STAGES=1: single registered adder, latency 1, with the same handshake.
- Simultaneous accept and output transfer in the same cycle are legal. Full throughput is kept.

Optional Feature:
- PIPELINED_ADDER_FLAGS_EN.
- Defined: flags computed as above, and the MSB skew registers exist.
- Undefined: flags is tied to 4'b0000, and the MSB/carry-out flag logic and its registers are not generated. sum, tag and handshake behaviour are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - typedef flags_t (packed struct n, z, c, v).
  - localparam bit positions FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Default WIDTH constant DATA_W=64.
- Sub-module adder_chunk: parametrised CW-bit combinational ripple adder with ports a, b, cin, s, cout. Instantiate it once per stage via generate.

Test Plan (WIDTH=64, STAGES=4, TAG_W=5):
- Wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0, tag=3.
  - Expect after 4 cycles: sum=0, flags N0 Z1 C1 V0, tag_out=3.
- Inter-chunk carry: a=64'h0000_0000_0000_FFFF, b=1.
  - Expect sum=64'h0000_0000_0001_0000 and C=0.
  - Also a=64'h0000_FFFF_FFFF_FFFF, b=1 gives sum=64'h0001_0000_0000_0000, proving the carry propagates through 3 stages.
- Subtract: a=5, b=7, sub=1, cin=1.
  - Expect sum=64'hFFFF_FFFF_FFFF_FFFE, N1 Z0 C0 V0.
  - Also a=7, b=5 gives sum=2, C1.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1.
  - Expect sum=64'h8000_0000_0000_0000, N1 V1 C0.
- Streaming plus stall: 8 back-to-back ops with tags 0..7 and out_ready=1.
  - Results arrive on consecutive cycles, in order.
  - Then hold out_ready=0 for 3 cycles with out_valid=1.
  - Expect in_ready=0, outputs stable, no loss or duplication after release.
- Reset mid-flight: accept 2 ops, then assert reset_n=0 asynchronously between edges.
  - Expect out_valid=0 immediately, and no stale result after release.
  - A new op completes with latency 4.
